// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a synchronous FIFO onto a valid/ready stream through a small skid buffer
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 1;

  logic [FIFO_WIDTH-1:0] skid_buf [SKID_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  infl;
  logic                  pop;
  logic                  capture;
  logic                  rd_en;
  logic [SUM_W-1:0]      committed;

  assign m_valid = (occ != '0);
  assign m_data  = skid_buf[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign capture = infl & ~flush;

  // Slots already spoken for (held + in flight) after this edge's pop; a read
  // is only issued when the word it returns is guaranteed a free slot.
  assign committed  = {1'b0, occ} + SUM_W'(infl) - SUM_W'(pop);
  assign rd_en      = rst_n & ~fifo_empty & ~flush & (committed < SUM_W'(SKID_DEPTH));
  assign fifo_rd_en = rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      infl   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_buf[i] <= '0;
      end
    end else if (flush) begin
      occ    <= '0;
      infl   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      infl <= rd_en;
      occ  <= occ + OCC_W'(capture) - OCC_W'(pop);
      if (capture) begin
        skid_buf[wr_ptr] <= fifo_data_out;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      if (rd_en && fifo_underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
